motor_dir_sequencer: RTL and testbench
======================================

// Module: motor_dir_sequencer
// PURPOSE
//  Command-level controller that generates the raw PWM and direction signals
//    feeding the H-bridge deadtime/routing stage.
//  Ramps the duty cycle toward a commanded target, once per PWM period.
//  Sequences direction reversals safely: ramp to 0, coast, switch dir, ramp up.
//  Supports an emergency stop that kills PWM immediately.
// PARAMETERS
//  CNT_W      8    PWM counter/duty width; PWM period = 2**CNT_W clk cycles
//  RAMP_STEP  16   duty change applied per PWM period while ramping
//  COAST_CYC  1000 clk cycles PWM held low between ramp-down and dir switch (>=1)
// PORTS
//  clk        in   1      system clock (100 MHz)
//  rst_n      in   1      asynchronous, active-low reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      command accepted when cmd_valid & cmd_ready at posedge clk
//  cmd_dir    in   1      requested direction (0/1, matches H-bridge dir input)
//  cmd_duty   in   CNT_W  requested duty; high time = cmd_duty clks per period
//  estop      in   1      synchronous emergency stop, level, highest priority
//  pwm_out    out  1      registered PWM to deadtime stage
//  dir_out    out  1      registered direction to deadtime stage
//  busy       out  1      state != IDLE
//  state_o    out  3      current FSM state encoding (debug)
// BEHAVIOUR
//  Reset: state=IDLE, duty_cur=0, target=0, pwm_cnt=0, pwm_out=0, dir_out=0, pending cleared.
//  pwm_cnt free-runs 0..2**CNT_W-1 in every state and wraps to 0.
//  pwm_out <= (pwm_cnt < duty_cur): one clk behind the counter; duty 0 gives constant 0.
//  Maximum duty is (2**CNT_W-1)/2**CNT_W.
//  duty_cur updates only on the wrap cycle (pwm_cnt == all-ones), so there are no mid-period glitches.
//  Ramp rule at wrap: if duty_cur<target, duty_cur=min(duty_cur+RAMP_STEP,target);
//    if duty_cur>target, duty_cur=max(duty_cur-RAMP_STEP,target).
//    Compute with CNT_W+1 bits; never overflow or underflow.
//  cmd_ready = (state==IDLE || state==RUN) && !estop. It is combinational from registered state.
//  FSM states: IDLE=0, RUN=1, RAMP_DOWN=2, COAST=3, SWITCH=4.
//  IDLE: duty_cur=0.
//    Accepted cmd with cmd_dir==dir_out and duty>0: target=cmd_duty, go RUN.
//    Accepted cmd with cmd_dir!=dir_out: latch pending dir/duty, go COAST.
//    Accepted cmd with same dir and duty 0: ignored, stay IDLE.
//  RUN:
//    Accepted cmd with same dir: target=cmd_duty immediately (ramp continues from duty_cur).
//    Accepted cmd with different dir: latch pending dir/duty, target=0, go RAMP_DOWN.
//    When target==0 and duty_cur==0: go IDLE.
//  RAMP_DOWN: ramps toward 0; no commands accepted; when duty_cur==0 go COAST.
//  COAST: pwm_out held 0; coast_cnt cleared on entry.
//    Leave after COAST_CYC cycles: to SWITCH if pending valid, else IDLE.
//  SWITCH: exactly 1 cycle; dir_out<=pending dir; target<=pending duty; clear pending.
//    Next state RUN if pending duty>0, else IDLE.
//  dir_out changes only in SWITCH, so it never changes while duty_cur != 0.
//  estop high, any state: duty_cur=0, target=0, pending cleared, pwm_out=0 next clk.
//    State goes to COAST with coast_cnt held at 0 while estop is high.
//    After estop falls: coast completes, then IDLE; dir_out unchanged.
//  Simultaneous estop and cmd handshake: estop wins; cmd_ready is already 0, so nothing is accepted.
//  rst_n low mid-operation: all regs to reset values asynchronously; pwm_out=0 immediately.
// TESTING
//  (CNT_W=8, RAMP_STEP=16, COAST_CYC=20 unless noted)
//  1 Reset release, no cmd -> pwm_out=0, dir_out=0, busy=0, cmd_ready=1, state_o=0.
//  2 IDLE, cmd dir=0 duty=64:
//    -> high time 16,32,48,64 clks in periods 1..4, then steady 64/256.
//  3 RUN dir=0 duty=200, cmd dir=1 duty=100:
//    -> duty steps down by 16 per period to 0 (last step 8->0), then 20 clks coast,
//       dir_out=1 in SWITCH, ramp up to 100 (last step 96->100).
//    -> Check pwm_out never high while dir_out toggles.
//  4 RUN duty=128, assert estop for 3 clks -> pwm_out 0 one clk after estop;
//    cmd_ready=0; 20 clks after release state=IDLE, dir_out unchanged.
//  5 RUN duty=48, cmd same dir duty=0 -> ramp 32,16,0 then IDLE, busy=0.
//    During ramp, cmd duty=80 retargets upward with no stall.
//  6 Assert rst_n low mid-COAST -> outputs reset immediately; next cmd accepted from IDLE.

Source files
------------

// File: rtl/motor_dir_sequencer_if.sv
// Command channel into the motor direction sequencer.
// Valid/ready handshake carrying the requested direction and duty.
interface motor_dir_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_duty;

  modport master (
    output cmd_valid,
    output cmd_dir,
    output cmd_duty,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_dir,
    input  cmd_duty,
    output cmd_ready
  );
endinterface

// File: rtl/motor_dir_sequencer.sv
// Ramped PWM/direction command sequencer for the H-bridge front end.
// Reversals go ramp-down, coast, switch, ramp-up; estop forces a coast.
module motor_dir_sequencer #(
  parameter int CNT_W     = 8,
  parameter int RAMP_STEP = 16,
  parameter int COAST_CYC = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  motor_dir_sequencer_if.slave  cmd,
  input  logic                  estop,
  output logic                  pwm_out,
  output logic                  dir_out,
  output logic                  busy,
  output logic [2:0]            state_o
);

  localparam int CO_W = (COAST_CYC > 1) ? $clog2(COAST_CYC) : 1;
  localparam logic [CO_W-1:0] CO_LAST = CO_W'(COAST_CYC - 1);
  localparam logic [CNT_W:0]  STEP = (CNT_W+1)'(RAMP_STEP);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    RAMP_DOWN = 3'd2,
    COAST     = 3'd3,
    SWITCH    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic             pv_q, pv_d;
  logic             pdir_q, pdir_d;
  logic [CNT_W-1:0] pduty_q, pduty_d;
  logic [CO_W-1:0]  coast_q, coast_d;
  logic             dir_d;
  logic             pwm_d;

  logic             wrap;
  logic             acc;
  logic             same;
  logic [CNT_W:0]   up_sum;
  logic [CNT_W:0]   dn_dif;
  logic [CNT_W-1:0] ramp_val;

  assign wrap = &cnt_q;
  assign cmd.cmd_ready = (state_q == IDLE || state_q == RUN) && !estop;
  assign acc  = cmd.cmd_valid && cmd.cmd_ready;
  assign same = (cmd.cmd_dir == dir_out);
  assign busy = (state_q != IDLE);
  assign state_o = state_q;

  // One extra bit so the step can neither wrap past max nor borrow below 0.
  assign up_sum = {1'b0, duty_q} + STEP;
  assign dn_dif = {1'b0, duty_q} - STEP;

  always_comb begin
    ramp_val = duty_q;
    if (duty_q < tgt_q) begin
      ramp_val = (up_sum > {1'b0, tgt_q}) ? tgt_q : up_sum[CNT_W-1:0];
    end else if (duty_q > tgt_q) begin
      ramp_val = (dn_dif[CNT_W] || dn_dif < {1'b0, tgt_q}) ?
                 tgt_q : dn_dif[CNT_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    duty_d  = wrap ? ramp_val : duty_q;
    tgt_d   = tgt_q;
    pv_d    = pv_q;
    pdir_d  = pdir_q;
    pduty_d = pduty_q;
    coast_d = coast_q;
    dir_d   = dir_out;
    pwm_d   = (state_q != COAST) && (cnt_q < duty_q);
    if (estop) begin
      state_d = COAST;
      duty_d  = '0;
      tgt_d   = '0;
      pv_d    = 1'b0;
      coast_d = '0;
      pwm_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (acc && !same) begin
            pv_d    = 1'b1;
            pdir_d  = cmd.cmd_dir;
            pduty_d = cmd.cmd_duty;
            coast_d = '0;
            state_d = COAST;
          end else if (acc && cmd.cmd_duty != '0) begin
            tgt_d   = cmd.cmd_duty;
            state_d = RUN;
          end
        end
        RUN: begin
          if (acc && same) begin
            tgt_d = cmd.cmd_duty;
          end else if (acc) begin
            pv_d    = 1'b1;
            pdir_d  = cmd.cmd_dir;
            pduty_d = cmd.cmd_duty;
            tgt_d   = '0;
            state_d = RAMP_DOWN;
          end else if (tgt_q == '0 && duty_q == '0) begin
            state_d = IDLE;
          end
        end
        RAMP_DOWN: begin
          if (duty_q == '0) begin
            coast_d = '0;
            state_d = COAST;
          end
        end
        COAST: begin
          if (coast_q == CO_LAST) begin
            state_d = pv_q ? SWITCH : IDLE;
          end else begin
            coast_d = coast_q + 1'b1;
          end
        end
        SWITCH: begin
          dir_d   = pdir_q;
          tgt_d   = pduty_q;
          pv_d    = 1'b0;
          state_d = (pduty_q != '0) ? RUN : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      duty_q  <= '0;
      tgt_q   <= '0;
      pv_q    <= 1'b0;
      pdir_q  <= 1'b0;
      pduty_q <= '0;
      coast_q <= '0;
      dir_out <= 1'b0;
      pwm_out <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_q + 1'b1;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      pv_q    <= pv_d;
      pdir_q  <= pdir_d;
      pduty_q <= pduty_d;
      coast_q <= coast_d;
      dir_out <= dir_d;
      pwm_out <= pwm_d;
    end
  end

endmodule

// File: tb/tb_motor_dir_sequencer.sv
// Bench for motor_dir_sequencer: directed scenarios plus random commands,
// all run in lockstep against a period-level behavioural model.
module tb_motor_dir_sequencer;
  localparam int CNT_W = 8;
  localparam int STEP  = 16;
  localparam int COAST = 20;
  localparam int PER   = 256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       estop = 1'b0;
  logic       pwm_out;
  logic       dir_out;
  logic       busy;
  logic [2:0] state_o;

  motor_dir_sequencer_if #(.CNT_W(CNT_W)) cmd_if();

  motor_dir_sequencer #(
    .CNT_W(CNT_W),
    .RAMP_STEP(STEP),
    .COAST_CYC(COAST)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd(cmd_if),
    .estop(estop),
    .pwm_out(pwm_out),
    .dir_out(dir_out),
    .busy(busy),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int m_state, m_duty, m_tgt, m_cnt, m_dir, m_pwm;
  int m_pv, m_pdir, m_pduty, m_cstart;
  int cyc = 0;
  int hi_acc = 0;
  int hp[$];
  int prev_dir = 0;
  int prev_pwm = 0;

  function automatic int ramp_to(int d, int t);
    if (d < t) return (d + STEP < t) ? d + STEP : t;
    if (d > t) return (d - STEP > t) ? d - STEP : t;
    return d;
  endfunction

  task automatic model_reset();
    m_state = 0; m_duty = 0; m_tgt = 0; m_cnt = 0;
    m_dir = 0; m_pwm = 0; m_pv = 0; m_pdir = 0;
    m_pduty = 0; m_cstart = 0;
  endtask

  // Model in terms of the spec: phases, periods, coast deadline by timestamp.
  task automatic model_edge();
    int ns, nd, nt, np, cd, cv;
    bit acc;
    cyc++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    cd  = int'(cmd_if.cmd_dir);
    cv  = int'(cmd_if.cmd_duty);
    acc = cmd_if.cmd_valid && !estop && (m_state <= 1);
    np  = (!estop && m_state != 3 && m_cnt < m_duty) ? 1 : 0;
    nd  = (m_cnt == PER - 1) ? ramp_to(m_duty, m_tgt) : m_duty;
    nt  = m_tgt;
    ns  = m_state;
    if (estop) begin
      nd = 0; nt = 0; m_pv = 0; ns = 3; m_cstart = cyc;
    end else begin
      case (m_state)
        0: if (acc && cd != m_dir) begin
             m_pv = 1; m_pdir = cd; m_pduty = cv;
             ns = 3; m_cstart = cyc;
           end else if (acc && cv != 0) begin
             nt = cv; ns = 1;
           end
        1: if (acc && cd == m_dir) nt = cv;
           else if (acc) begin
             m_pv = 1; m_pdir = cd; m_pduty = cv;
             nt = 0; ns = 2;
           end else if (m_tgt == 0 && m_duty == 0) ns = 0;
        2: if (m_duty == 0) begin ns = 3; m_cstart = cyc; end
        3: if (cyc - m_cstart == COAST) ns = m_pv ? 4 : 0;
        4: begin
             m_dir = m_pdir; nt = m_pduty; m_pv = 0;
             ns = (m_pduty != 0) ? 1 : 0;
           end
        default: ns = 0;
      endcase
    end
    m_state = ns; m_duty = nd; m_tgt = nt;
    m_cnt = (m_cnt + 1) % PER;
    m_pwm = np;
  endtask

  task automatic tick();
    int oc;
    bit rdy;
    @(posedge clk);
    oc = m_cnt;
    model_edge();
    #1;
    hi_acc += int'(pwm_out);
    if (oc == PER - 1) begin
      if (hi_acc != 0) hp.push_back(hi_acc);
      hi_acc = 0;
    end
    rdy = !estop && (m_state <= 1);
    checks++;
    if (pwm_out !== m_pwm[0] || dir_out !== m_dir[0] ||
        busy !== (m_state != 0) || state_o !== m_state[2:0] ||
        cmd_if.cmd_ready !== rdy) begin
      errors++;
      $display("FAIL lockstep cyc=%0d got pwm=%b dir=%b busy=%b st=%0d rdy=%b want pwm=%0d dir=%0d st=%0d rdy=%b",
               cyc, pwm_out, dir_out, busy, state_o, cmd_if.cmd_ready,
               m_pwm, m_dir, m_state, rdy);
    end
    if (dir_out !== prev_dir[0]) begin
      checks++;
      if (pwm_out === 1'b1 || prev_pwm == 1) begin
        errors++;
        $display("FAIL dir_toggle cyc=%0d got pwm=%b prev_pwm=%0d want 0", cyc, pwm_out, prev_pwm);
      end
    end
    prev_dir = int'(dir_out);
    prev_pwm = int'(pwm_out);
  endtask

  task automatic send(input int dir, input int duty);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_dir   = dir[0];
    cmd_if.cmd_duty  = duty[7:0];
    tick();
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_for(input bit on_state, input int val,
                          input int budget, input string tag);
    int n = 0;
    while ((on_state ? m_state : m_duty) != val && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if ((on_state ? m_state : m_duty) != val) begin
      errors++;
      $display("FAIL %s timeout got %0d want %0d", tag,
               on_state ? m_state : m_duty, val);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_dir = 1'b0;
    cmd_if.cmd_duty = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks += 5;
    if (pwm_out !== 1'b0) begin errors++; $display("FAIL reset_pwm got %b want 0", pwm_out); end
    if (dir_out !== 1'b0) begin errors++; $display("FAIL reset_dir got %b want 0", dir_out); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cmd_if.cmd_ready); end
    if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_o); end
  endtask

  task automatic test_ramp_up();
    int exp[$] = '{16, 32, 48, 64, 64};
    int n = 0;
    hp.delete();
    send(0, 64);
    while (hp.size() < exp.size() && n < 2000) begin tick(); n++; end
    foreach (exp[i]) begin
      checks++;
      if (hp.size() <= i || hp[i] != exp[i]) begin
        errors++;
        $display("FAIL ramp_up period %0d got %0d want %0d", i,
                 hp.size() > i ? hp[i] : -1, exp[i]);
      end
    end
  endtask

  task automatic test_reverse();
    int exp[$];
    int n = 0, coast_n = 0, sw_n = 0;
    send(0, 200);
    wait_for(1'b0, 200, 4000, "reach_200");
    for (int d = 200; d > 0; d -= STEP) exp.push_back(d);
    for (int d = STEP; d < 100; d += STEP) exp.push_back(d);
    exp.push_back(100);
    hp.delete();
    send(1, 100);
    while (hp.size() < exp.size() && n < 8000) begin
      tick();
      n++;
      if (state_o === 3'd3) coast_n++;
      if (state_o === 3'd4) sw_n++;
    end
    foreach (exp[i]) begin
      checks++;
      if (hp.size() <= i || hp[i] != exp[i]) begin
        errors++;
        $display("FAIL reverse period %0d got %0d want %0d", i,
                 hp.size() > i ? hp[i] : -1, exp[i]);
      end
    end
    checks += 3;
    if (coast_n != COAST) begin errors++; $display("FAIL coast_len got %0d want %0d", coast_n, COAST); end
    if (sw_n != 1) begin errors++; $display("FAIL switch_len got %0d want 1", sw_n); end
    if (dir_out !== 1'b1) begin errors++; $display("FAIL reverse_dir got %b want 1", dir_out); end
  endtask

  task automatic test_estop();
    send(1, 128);
    wait_for(1'b0, 128, 2000, "reach_128");
    estop = 1'b1;
    tick();
    checks += 3;
    if (pwm_out !== 1'b0) begin errors++; $display("FAIL estop_pwm got %b want 0", pwm_out); end
    if (cmd_if.cmd_ready !== 1'b0) begin errors++; $display("FAIL estop_ready got %b want 0", cmd_if.cmd_ready); end
    if (state_o !== 3'd3) begin errors++; $display("FAIL estop_state got %0d want 3", state_o); end
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_dir = 1'b0;
    cmd_if.cmd_duty = 8'd90;
    tick();
    cmd_if.cmd_valid = 1'b0;
    tick();
    estop = 1'b0;
    repeat (COAST - 1) tick();
    checks++;
    if (state_o !== 3'd3) begin errors++; $display("FAIL estop_coast got %0d want 3", state_o); end
    tick();
    checks += 3;
    if (state_o !== 3'd0) begin errors++; $display("FAIL estop_idle got %0d want 0", state_o); end
    if (dir_out !== 1'b1) begin errors++; $display("FAIL estop_dir got %b want 1", dir_out); end
    if (busy !== 1'b0) begin errors++; $display("FAIL estop_busy got %b want 0", busy); end
  endtask

  task automatic test_retarget();
    int exp1[$] = '{48, 32, 16};
    int exp2[$] = '{48, 32, 48, 64, 80};
    send(1, 48);
    wait_for(1'b0, 48, 1500, "reach_48a");
    hp.delete();
    send(1, 0);
    wait_for(1'b1, 0, 2000, "back_idle");
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL retarget_busy got %b want 0", busy); end
    if (hp.size() != exp1.size()) begin
      errors++; $display("FAIL ramp_down_len got %0d want %0d", hp.size(), exp1.size());
    end
    foreach (exp1[i]) begin
      checks++;
      if (hp.size() <= i || hp[i] != exp1[i]) begin
        errors++;
        $display("FAIL ramp_down period %0d got %0d want %0d", i,
                 hp.size() > i ? hp[i] : -1, exp1[i]);
      end
    end
    send(1, 48);
    wait_for(1'b0, 48, 1500, "reach_48b");
    hp.delete();
    send(1, 0);
    wait_for(1'b0, 32, 600, "reach_32");
    send(1, 80);
    wait_for(1'b0, 80, 1500, "reach_80");
    repeat (PER) tick();
    foreach (exp2[i]) begin
      checks++;
      if (hp.size() <= i || hp[i] != exp2[i]) begin
        errors++;
        $display("FAIL retarget period %0d got %0d want %0d", i,
                 hp.size() > i ? hp[i] : -1, exp2[i]);
      end
    end
  endtask

  task automatic test_reset_mid_coast();
    send(1, 0);
    wait_for(1'b1, 0, 3000, "idle_pre_rst");
    send(0, 32);
    repeat (5) tick();
    checks++;
    if (state_o !== 3'd3) begin errors++; $display("FAIL pre_rst_coast got %0d want 3", state_o); end
    #2;
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (pwm_out !== 1'b0) begin errors++; $display("FAIL arst_pwm got %b want 0", pwm_out); end
    if (dir_out !== 1'b0) begin errors++; $display("FAIL arst_dir got %b want 0", dir_out); end
    if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b want 0", busy); end
    if (state_o !== 3'd0) begin errors++; $display("FAIL arst_state got %0d want 0", state_o); end
    model_reset();
    hi_acc = 0;
    tick();
    rst_n = 1'b1;
    tick();
    send(0, 32);
    checks++;
    if (state_o !== 3'd1) begin errors++; $display("FAIL post_rst_cmd got %0d want 1", state_o); end
  endtask

  task automatic test_random();
    bit d = 1'b0;
    repeat (6000) begin
      cmd_if.cmd_valid = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) d = ~d;
      cmd_if.cmd_dir = d;
      cmd_if.cmd_duty = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      estop = ($urandom_range(0, 399) == 0);
      tick();
    end
    cmd_if.cmd_valid = 1'b0;
    estop = 1'b0;
    repeat (50) tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ramp_up();
    test_reverse();
    test_estop();
    test_retarget();
    test_reset_mid_coast();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
